cs_add_seq: RTL and testbench
=============================

# cs_add_seq

Multi-cycle wide adder built around one 4-bit `carry_select_adder` slice. It accepts WIDTH-bit operands through a valid/ready handshake and adds them one nibble per cycle, least significant nibble first. The nibble carry is held in a register between cycles, and the full result is returned through a second valid/ready handshake. It serves as the shared, area-lean addition resource for datapaths that do not need single-cycle wide adds.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a multiple of 4 and at least 8. `NIBBLES = WIDTH/4`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands and `cin` are valid.
- `in_ready`  out  1: block can accept an operation. High only in IDLE.
- `a`, `b`  in  WIDTH: operands, sampled on the accept edge.
- `cin`  in  1: carry-in, sampled on the accept edge.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: consumer takes the result.
- `sum`  out  WIDTH: `(a+b+cin) mod 2^WIDTH`.
- `cout`  out  1: carry out of bit WIDTH-1.
- `overflow`  out  1: two's-complement overflow, defined as `a[W-1]==b[W-1] && sum[W-1]!=a[W-1]`.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a`, `b`; set carry register to `cin`; set nibble index to 0; go to RUN.
- **RUN**
  - The slice gets `a[4i+3:4i]`, `b[4i+3:4i]` and the carry register.
  - Each edge: write the slice S into `sum[4i+3:4i]`, load the slice cout into the carry register, and increment `i`.
  - On the edge where `i==NIBBLES-1`: go to DONE, set `cout` to the final slice carry, and compute `overflow`.
- **DONE**
  - `out_valid`=1, `in_ready`=0.
  - `sum`, `cout` and `overflow` are held stable.
  - On `out_valid && out_ready`: go to IDLE.
- `in_valid` outside IDLE is ignored. No queuing; the requester must hold its request until `in_ready`.
- Operands are captured on accept. Input changes after accept do not affect the result.
- `sum` is updated in place during RUN and is meaningful only while `out_valid`=1. Between operations it holds the last result.
- Reset while in RUN or DONE aborts the operation. The partial result is discarded and there is no completion.

## Timing
- Reset values:
  - state=IDLE, so `in_ready`=1.
  - `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0.
  - carry register and index are 0.
- Latency: `out_valid` rises exactly NIBBLES edges after the accept edge (4 edges for WIDTH=16).
- DONE→IDLE takes one edge after the output handshake, so `in_ready` is high in the following cycle.
- The minimum issue interval is NIBBLES+2 cycles (accept, NIBBLES RUN edges, output handshake); with `out_ready` held high every result is taken in its first DONE cycle.
- `in_ready` is a combinational decode of state=IDLE. All other outputs are registered.
- The slice is purely combinational. Its path is operand mux → slice → `sum` nibble/carry register, all within one cycle.

## Structure
- Package `cs_add_pkg`:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - `NIB_W`=4.
- Sub-module: exactly one instance of the existing 4-bit `carry_select_adder`.
- Operand nibble selection uses an indexed part-select on the latched operands.
- The index counter is `$clog2(NIBBLES)` bits wide.
- Elaboration assertion: `WIDTH % 4 == 0` and `WIDTH >= 8`.

## Test plan
- **Reset mid-operation:** drop `rst_n` during RUN, asynchronously and mid-cycle. Required: `out_valid`=0, `sum`=0, `cout`=0 immediately; `in_ready`=1 after release; no stale result appears.
- **Basic add, latency check:** WIDTH=16, `a`=16'h00FF, `b`=16'h0001, `cin`=0. Required: `sum`=16'h0100, `cout`=0, `overflow`=0; `out_valid` exactly 4 edges after accept.
- **Full carry ripple:** `a`=16'hFFFF, `b`=0, `cin`=1. Required: `sum`=16'h0000, `cout`=1, `overflow`=0.
- **Signed overflow:** `a`=16'h7FFF, `b`=16'h0001, `cin`=0. Required: `sum`=16'h8000, `cout`=0, `overflow`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE while pulsing `in_valid` with new operands. Required:
  - `sum`, `cout`, `overflow` and `out_valid` stable; `in_ready`=0; the pulses are ignored.
  - After the handshake, `in_ready`=1 the next cycle and the next operation is accepted and completes correctly.
- **Random regression:** 1000 random operations at WIDTH=8 and WIDTH=32, with random `in_valid`/`out_ready` gaps and `a`/`b` also driven from the extremes {0, all-ones, MSB-only}. Required: {`cout`, `sum`} equals `a+b+cin` and `overflow` matches the signed model every time.

Source files
------------

// File: rtl/cs_add_pkg.sv
// cs_add_pkg: shared definitions for the multi-cycle nibble-serial adder.
//   NIB_W   - width of one adder slice (one nibble)
//   state_e - controller states (IDLE, RUN, DONE)
package cs_add_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/cs_add_seq_csa.sv
// carry_select_adder: purely combinational 4-bit carry-select adder slice.
//   a, b  in  4 : nibble operands
//   cin   in  1 : carry-in
//   s     out 4 : nibble sum
//   cout  out 1 : carry-out
module carry_select_adder
    import cs_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;
    logic [2:0] hi;

    always_comb begin
        lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
        // Upper half is precomputed for both possible carries and picked by the lower carry.
        hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
        hi1 = hi0 + 3'd1;
        hi  = lo[2] ? hi1 : hi0;
        s   = {hi[1:0], lo[1:0]};
        cout = hi[2];
    end

endmodule

// File: rtl/cs_add_seq.sv
// cs_add_seq: WIDTH-bit adder evaluated one nibble per cycle through a single
// carry_select_adder slice, LS nibble first, with valid/ready on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b, cin            : operands and carry-in, captured on accept
//   out_valid / out_ready: result handshake
//   sum, cout, overflow  : registered result, held until taken
module cs_add_seq
    import cs_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = $clog2(NIBBLES);

    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("cs_add_seq: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;

    logic [NIB_W-1:0]   slice_a;
    logic [NIB_W-1:0]   slice_b;
    logic [NIB_W-1:0]   slice_s;
    logic               slice_co;

    assign slice_a = a_q[NIB_W*int'(idx_q) +: NIB_W];
    assign slice_b = b_q[NIB_W*int'(idx_q) +: NIB_W];

    carry_select_adder u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[NIB_W*int'(idx_q) +: NIB_W] = slice_s;
                carry_d = slice_co;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    idx_d       = '0;
                    cout_d      = slice_co;
                    // The top nibble's MSB is the final sum MSB, so overflow is known this edge.
                    ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                  (slice_s[NIB_W-1] != a_q[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cs_add_seq.sv
module tb_cs_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_r = '0;
    logic [31:0] b_r = '0;
    logic        cin_r = 1'b0;

    logic        iv16 = 1'b0, or16 = 1'b0, ir16, ov16, co16, of16;
    logic [15:0] s16;
    logic        iv8 = 1'b0, or8 = 1'b0, ir8, ov8, co8, of8;
    logic [7:0]  s8;
    logic        iv32 = 1'b0, or32 = 1'b0, ir32, ov32, co32, of32;
    logic [31:0] s32;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cs_add_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a_r[15:0]), .b(b_r[15:0]), .cin(cin_r), .out_valid(ov16),
        .out_ready(or16), .sum(s16), .cout(co16), .overflow(of16)
    );

    cs_add_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a_r[7:0]), .b(b_r[7:0]), .cin(cin_r), .out_valid(ov8),
        .out_ready(or8), .sum(s8), .cout(co8), .overflow(of8)
    );

    cs_add_seq #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a_r), .b(b_r), .cin(cin_r), .out_valid(ov32),
        .out_ready(or32), .sum(s32), .cout(co32), .overflow(of32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        of;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one WIDTH=16 operation and wait for out_valid; lat = edges from accept to out_valid.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
        int t;
        @(negedge clk);
        a_r = {16'h0, a};
        b_r = {16'h0, b};
        cin_r = c;
        iv16 = 1'b1;
        t = 0;
        while (!ir16 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("op16_ready_timeout", 0, 1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        a_r = $urandom;
        b_r = $urandom;
        cin_r = ~c;
        lat = 0;
        while (!ov16 && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take16();
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check("in_ready_after_take", {62'h0, ir16, ov16}, 64'h2);
    endtask

    function automatic logic [31:0] pick(input logic [31:0] mask, input logic [31:0] msb);
        case ($urandom_range(0, 3))
            0: return '0;
            1: return mask;
            2: return msb;
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic rnd_op(input int w);
        logic [31:0] mask, msb, a, b, gs;
        logic        c, gco, gof, eco, eof;
        logic [63:0] full;
        logic [31:0] es;
        int t;
        mask = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
        msb  = (w == 8) ? 32'h80 : 32'h8000_0000;
        a = pick(mask, msb);
        b = pick(mask, msb);
        c = 1'($urandom_range(0, 1));
        full = {32'h0, a} + {32'h0, b} + {63'h0, c};
        es  = full[31:0] & mask;
        eco = full[w];
        eof = (a[w-1] == b[w-1]) && (es[w-1] != a[w-1]);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        a_r = a; b_r = b; cin_r = c;
        if (w == 8) iv8 = 1'b1; else iv32 = 1'b1;
        t = 0;
        while (!((w == 8) ? ir8 : ir32) && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("rand_ready_timeout", 0, 1);
        @(posedge clk); #1;
        iv8 = 1'b0; iv32 = 1'b0;
        a_r = $urandom; b_r = $urandom; cin_r = ~c;
        repeat ($urandom_range(0, 6)) @(negedge clk);
        if (w == 8) or8 = 1'b1; else or32 = 1'b1;
        t = 0;
        while (!((w == 8) ? ov8 : ov32) && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("rand_valid_timeout", 0, 1);
        gs  = (w == 8) ? {24'h0, s8} : s32;
        gco = (w == 8) ? co8 : co32;
        gof = (w == 8) ? of8 : of32;
        check((w == 8) ? "rand_w8" : "rand_w32", {30'h0, gco, gof, gs}, {30'h0, eco, eof, es});
        @(posedge clk); #1;
        or8 = 1'b0; or32 = 1'b0;
    endtask

    initial begin
        int lat;
        logic bad;
        logic [15:0] hold_s;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0FF0, 16'h0010, 1'b1, 16'h1001, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_state", {44'h0, ir16, ov16, co16, of16, s16}, {44'h0, 4'b1000, 16'h0000});

        for (int i = 0; i < 8; i++) begin
            op16(vecs[i].a, vecs[i].b, vecs[i].c, lat);
            check($sformatf("latency_v%0d", i), 64'(lat), 64'd4);
            check($sformatf("result_v%0d", i), {46'h0, co16, of16, s16},
                  {46'h0, vecs[i].co, vecs[i].of, vecs[i].s});
            take16();
        end

        // Backpressure: result must hold and new requests are ignored.
        op16(16'h1111, 16'h2222, 1'b0, lat);
        hold_s = s16;
        check("bp_result", {46'h0, co16, of16, s16}, {46'h0, 2'b00, 16'h3333});
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv16 = i[0];
            a_r = $urandom; b_r = $urandom;
            @(posedge clk); #1;
            if (!ov16 || ir16 || s16 !== hold_s || co16 || of16) bad = 1'b1;
        end
        iv16 = 1'b0;
        check("bp_stable", {63'h0, bad}, 64'h0);
        take16();
        op16(16'hA5A5, 16'h5A5B, 1'b0, lat);
        check("bp_next_latency", 64'(lat), 64'd4);
        check("bp_next_result", {46'h0, co16, of16, s16}, {46'h0, 2'b10, 16'h0000});
        take16();

        // Reset during RUN, asynchronously and away from the clock edge.
        @(negedge clk);
        a_r = 32'h0000_ABCD; b_r = 32'h0000_1111; cin_r = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("reset_midrun", {44'h0, ir16, ov16, co16, of16, s16}, {44'h0, 4'b1000, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov16 || !ir16) bad = 1'b1;
        end
        check("no_stale_result", {63'h0, bad}, 64'h0);

        for (int i = 0; i < 1000; i++) rnd_op(8);
        for (int i = 0; i < 1000; i++) rnd_op(32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
